// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM encoding, default
// parameter values and the byte-address to SRAM word-offset mapping.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_SRAM_ADDR_W = 17;
    localparam int DEFAULT_BASE_ADDR   = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 5;
    localparam int DEFAULT_BURST_LEN   = 2;

    // Addresses below the base wrap around; callers keep only the low word-address bits.
    function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base_addr);
        logic [31:0] diff;
        diff = byte_addr - base_addr;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Core-side request bus of the SRAM burst controller; the memory stage is the
// master, the controller is the slave.
interface sram_burst_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) ();

    logic                          wr_en;
    logic                          rd_en;
    logic [31:0]                   addr;
    logic [DATA_W-1:0]             wdata;
    logic [BURST_LEN*DATA_W-1:0]   rdata;
    logic                          ready;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/sram_burst_ctrl_timer.sv
// Beat timer: reloading down-counter that flags the final core cycle of each
// SRAM beat while enabled.
module sram_wait_timer
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int               CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Auto-reload at zero so consecutive beats run with no dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en) begin
            count <= (count == '0) ? RELOAD : count - 1'b1;
        end
    end

    assign last = en && (count == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Single-clock SRAM controller: wait-stated single-word writes and aligned
// multi-word burst reads, stalling the core through ready.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SRAM_ADDR_W = DEFAULT_SRAM_ADDR_W,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int BURST_LEN   = DEFAULT_BURST_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_burst_ctrl_if.slave       bus,
    output logic                   SRAM_WE_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ
);

    localparam int                     BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [SRAM_ADDR_W-1:0] ALIGN_MASK = ~SRAM_ADDR_W'(BURST_LEN - 1);

    state_t                      state;
    state_t                      next_state;
    logic                        accept;
    logic                        beat_end;
    logic                        last_beat;
    logic [BEAT_W-1:0]           beat;
    logic [SRAM_ADDR_W-1:0]      woff;
    logic [SRAM_ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [BURST_LEN*DATA_W-1:0] rdata_q;

    assign accept = (state == IDLE) && (bus.wr_en || bus.rd_en);
    assign woff   = SRAM_ADDR_W'(word_offset(bus.addr, 32'(BASE_ADDR)));

    sram_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   ((state == WRITE) || (state == READ)),
        .last (beat_end)
    );

    generate
        if (BURST_LEN > 1) begin : g_beat
            logic [BEAT_W-1:0] beat_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    beat_q <= '0;
                end else if (accept) begin
                    beat_q <= '0;
                end else if ((state == READ) && beat_end) begin
                    beat_q <= beat_q + 1'b1;
                end
            end
            assign beat = beat_q;
        end else begin : g_no_beat
            assign beat = '0;
        end
    endgenerate

    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A write wins over a simultaneous read; the read request is simply not taken.
    always_comb begin
        next_state = state;
        bus.ready  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = !(bus.wr_en || bus.rd_en);
                if (bus.wr_en) begin
                    next_state = WRITE;
                end else if (bus.rd_en) begin
                    next_state = READ;
                end
            end
            WRITE: begin
                if (beat_end) begin
                    next_state = DONE;
                end
            end
            READ: begin
                if (beat_end && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Reads start at the burst-aligned word and step one word per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.wr_en ? woff : (woff & ALIGN_MASK);
            wdata_q <= bus.wdata;
        end else if ((state == READ) && beat_end) begin
            rdata_q[beat*DATA_W +: DATA_W] <= SRAM_DQ;
            if (!last_beat) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign SRAM_WE_N = (state != WRITE);
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = (state == WRITE) ? wdata_q : 'z;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: a default instance with a full SRAM model
// plus two small parameter-sweep instances with a patterned read-only SRAM.
module tb_sram_burst_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl_if #(.DATA_W(32), .BURST_LEN(2)) bus ();
    logic        sram_we_n;
    logic [16:0] sram_addr;
    wire  [31:0] sram_dq;
    logic [31:0] mem [0:131071];
    logic        preload_en;
    logic [16:0] preload_addr;
    logic [31:0] preload_data;

    assign sram_dq = sram_we_n ? mem[sram_addr] : 'z;

    always @(posedge clk) begin
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end else if (!sram_we_n) begin
            mem[sram_addr] <= sram_dq;
        end
    end

    sram_burst_ctrl #(
        .DATA_W(32), .SRAM_ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(5), .BURST_LEN(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .SRAM_WE_N(sram_we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
    );

    // Sweep instances read a pattern of 0xC0DE0000 | word address.
    sram_burst_ctrl_if #(.DATA_W(32), .BURST_LEN(4)) bus_a ();
    logic        we_n_a;
    logic [16:0] addr_a;
    wire  [31:0] dq_a;
    assign dq_a = we_n_a ? (32'hC0DE0000 | {15'd0, addr_a}) : 'z;

    sram_burst_ctrl #(
        .DATA_W(32), .SRAM_ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(1), .BURST_LEN(4)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .SRAM_WE_N(we_n_a), .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a)
    );

    sram_burst_ctrl_if #(.DATA_W(32), .BURST_LEN(1)) bus_b ();
    logic        we_n_b;
    logic [16:0] addr_b;
    wire  [31:0] dq_b;
    assign dq_b = we_n_b ? (32'hC0DE0000 | {15'd0, addr_b}) : 'z;

    sram_burst_ctrl #(
        .DATA_W(32), .SRAM_ADDR_W(17), .BASE_ADDR(1024), .WAIT_CYCLES(3), .BURST_LEN(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .SRAM_WE_N(we_n_b), .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b)
    );

    task automatic load_word(input logic [16:0] a, input logic [31:0] d);
        @(negedge clk);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        @(negedge clk);
        preload_en   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 17'd0 || bus.rdata !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: ready=%b we_n=%b addr=%h rdata=%h, expected 1 1 0 0",
                     bus.ready, sram_we_n, sram_addr, bus.rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_default();
        @(negedge clk);
        bus.addr  = 32'd1024;
        bus.wdata = 32'hDEADBEEF;
        bus.wr_en = 1'b1;
        #1;
        vectors++;
        if (bus.ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_c0_ready: got %b expected 0", bus.ready);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            // A late address change must not disturb an access already accepted.
            if (c == 2) bus.addr = 32'd2048;
            vectors++;
            if (c <= 5) begin
                if (sram_we_n !== 1'b0 || sram_addr !== 17'd0 || sram_dq !== 32'hDEADBEEF || bus.ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL write_c%0d: we_n=%b addr=%h dq=%h ready=%b, expected 0 0 deadbeef 0",
                             c, sram_we_n, sram_addr, sram_dq, bus.ready);
                end
            end else if (bus.ready !== 1'b1 || sram_we_n !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL write_c6_done: ready=%b we_n=%b, expected 1 1", bus.ready, sram_we_n);
            end
        end
        bus.wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem[0] !== 32'hDEADBEEF || bus.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_result: mem0=%h ready=%b, expected deadbeef 1", mem[0], bus.ready);
        end
    endtask

    task automatic test_burst_read();
        load_word(17'd5, 32'h11111111);
        load_word(17'd4, 32'h22222222);
        @(negedge clk);
        bus.addr  = 32'd1044;
        bus.rd_en = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            vectors++;
            if (c <= 10) begin
                if (sram_addr !== ((c <= 5) ? 17'd4 : 17'd5) || sram_we_n !== 1'b1 || bus.ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL read_c%0d: addr=%h we_n=%b ready=%b, expected %h 1 0",
                             c, sram_addr, sram_we_n, bus.ready, (c <= 5) ? 17'd4 : 17'd5);
                end
            end else if (bus.ready !== 1'b1 || bus.rdata !== 64'h11111111_22222222) begin
                miscompares++;
                $display("[TB] FAIL read_c11_data: ready=%b rdata=%h, expected 1 1111111122222222",
                         bus.ready, bus.rdata);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.addr  = 32'd1028;
        bus.wdata = 32'hCAFEF00D;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (sram_we_n !== 1'b0 || sram_addr !== 17'd1 || sram_dq !== 32'hCAFEF00D) begin
                    miscompares++;
                    $display("[TB] FAIL both_c1: we_n=%b addr=%h dq=%h, expected 0 1 cafef00d",
                             sram_we_n, sram_addr, sram_dq);
                end
            end else if (c >= 5) begin
                vectors++;
                if (bus.ready !== (c == 6) || (c == 6 && bus.rdata !== 64'h11111111_22222222)) begin
                    miscompares++;
                    $display("[TB] FAIL both_c%0d: ready=%b rdata=%h, expected %b 1111111122222222",
                             c, bus.ready, bus.rdata, c == 6);
                end
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem[1] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL both_mem1: got %h expected cafef00d", mem[1]);
        end
    endtask

    task automatic test_wrap();
        load_word(17'h1FFFE, 32'hAAAA0001);
        load_word(17'h1FFFF, 32'hBBBB0002);
        @(negedge clk);
        bus.addr  = 32'd1020;
        bus.rd_en = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1 || c == 6) begin
                vectors++;
                if (sram_addr !== ((c == 1) ? 17'h1FFFE : 17'h1FFFF)) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_addr_c%0d: got %h expected %h",
                             c, sram_addr, (c == 1) ? 17'h1FFFE : 17'h1FFFF);
                end
            end else if (c == 11) begin
                vectors++;
                if (bus.ready !== 1'b1 || bus.rdata !== 64'hBBBB0002_AAAA0001) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_data: ready=%b rdata=%h, expected 1 bbbb0002aaaa0001",
                             bus.ready, bus.rdata);
                end
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.addr  = 32'd1032;
        bus.wdata = 32'h0BADCAFE;
        bus.wr_en = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            case (c)
                3: begin
                    vectors++;
                    if (sram_we_n !== 1'b0 || sram_addr !== 17'd2 || sram_dq !== 32'h0BADCAFE) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_first: we_n=%b addr=%h dq=%h, expected 0 2 0badcafe",
                                 sram_we_n, sram_addr, sram_dq);
                    end
                end
                6, 7, 12, 13: begin
                    vectors++;
                    if (bus.ready !== (c == 6 || c == 13)) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_ready_c%0d: got %b expected %b", c, bus.ready, c == 6 || c == 13);
                    end
                    if (c == 6) bus.wdata = 32'h12345678;
                    if (c == 13) bus.wr_en = 1'b0;
                end
                8: begin
                    vectors++;
                    if (sram_we_n !== 1'b0 || sram_addr !== 17'd2 || sram_dq !== 32'h12345678) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_second: we_n=%b addr=%h dq=%h, expected 0 2 12345678",
                                 sram_we_n, sram_addr, sram_dq);
                    end
                end
                14: begin
                    vectors++;
                    if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || mem[2] !== 32'h12345678) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_idle: ready=%b we_n=%b mem2=%h, expected 1 1 12345678",
                                 bus.ready, sram_we_n, mem[2]);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        bus.addr  = 32'd1044;
        bus.rd_en = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sram_addr !== 17'd4 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_before: addr=%h ready=%b, expected 4 0", sram_addr, bus.ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (sram_addr !== 17'd0 || bus.rdata !== 64'd0 || sram_we_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_clear: addr=%h rdata=%h we_n=%b, expected 0 0 1",
                     sram_addr, bus.rdata, sram_we_n);
        end
        bus.rd_en = 1'b0;
        #1;
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_ready: got %b expected 1", bus.ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c >= 10) begin
                vectors++;
                if (bus.ready !== (c == 11) || (c == 11 && bus.rdata !== 64'h11111111_22222222)) begin
                    miscompares++;
                    $display("[TB] FAIL rstmid_reread_c%0d: ready=%b rdata=%h, expected %b 1111111122222222",
                             c, bus.ready, bus.rdata, c == 11);
                end
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_param_sweep();
        @(negedge clk);
        bus_a.addr  = 32'd1048;
        bus_a.rd_en = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (c <= 4) begin
                if (addr_a !== 17'(3 + c) || bus_a.ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_a_c%0d: addr=%h ready=%b, expected %h 0", c, addr_a, bus_a.ready, 3 + c);
                end
            end else if (bus_a.ready !== 1'b1 ||
                         bus_a.rdata !== 128'hC0DE0007_C0DE0006_C0DE0005_C0DE0004) begin
                miscompares++;
                $display("[TB] FAIL sweep_a_done: ready=%b rdata=%h, expected 1 c0de0007c0de0006c0de0005c0de0004",
                         bus_a.ready, bus_a.rdata);
            end
        end
        bus_a.rd_en = 1'b0;
        @(negedge clk);
        bus_b.addr  = 32'd1060;
        bus_b.rd_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if (c <= 3) begin
                if (addr_b !== 17'd9 || bus_b.ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_b_c%0d: addr=%h ready=%b, expected 9 0", c, addr_b, bus_b.ready);
                end
            end else if (bus_b.ready !== 1'b1 || bus_b.rdata !== 32'hC0DE0009) begin
                miscompares++;
                $display("[TB] FAIL sweep_b_done: ready=%b rdata=%h, expected 1 c0de0009", bus_b.ready, bus_b.rdata);
            end
        end
        bus_b.rd_en = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        preload_en   = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus_a.wr_en  = 1'b0;
        bus_a.rd_en  = 1'b0;
        bus_a.addr   = '0;
        bus_a.wdata  = '0;
        bus_b.wr_en  = 1'b0;
        bus_b.rd_en  = 1'b0;
        bus_b.addr   = '0;
        bus_b.wdata  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_default();
        test_burst_read();
        test_simultaneous();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised single-clock SRAM controller between the ARM core's memory stage and the 17-bit-address, 32-bit-data off-chip SRAM. Replaces the half-rate SRAM clock with a programmable wait-state count on the core clock. Adds multi-word burst reads for cache-line fills; writes stay single-word. Stalls the pipeline through `ready` until each access completes.

## Interface
- `DATA_W`, 32: SRAM data width.
- `SRAM_ADDR_W`, 17: SRAM word-address width.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 5: core cycles per SRAM beat; must be ≥1.
- `BURST_LEN`, 2: words per read; must be a power of two, ≥1.

Ports:
- `clk`  in  1  core clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request; level, held by the requester.
- `rd_en`  in  1  read request; level, held by the requester.
- `addr`  in  32  byte address.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  BURST_LEN*DATA_W  burst read data; beat b sits in bits [b*DATA_W +: DATA_W].
- `ready`  out  1  low while an access is pending or in progress.
- `SRAM_WE_N`  out  1  SRAM write enable, active-low.
- `SRAM_ADDR`  out  SRAM_ADDR_W  SRAM word address.
- `SRAM_DQ`  inout  DATA_W  SRAM data bus.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - `wr_en` high → WRITE. `wr_en` takes priority when both requests are high; the read is ignored.
  - else `rd_en` high → READ.
- On acceptance, latch `wdata` and the word offset `woff = ((addr - BASE_ADDR) >> 2)` truncated to SRAM_ADDR_W bits. Negative or oversize offsets wrap modulo 2^SRAM_ADDR_W.
- Request inputs are ignored after acceptance until the controller returns to IDLE.
- WRITE, for WAIT_CYCLES cycles:
  - `SRAM_ADDR` = woff.
  - `SRAM_WE_N` = 0.
  - `SRAM_DQ` driven with the latched wdata.
  - Then → DONE.
- READ, for BURST_LEN beats of WAIT_CYCLES cycles each:
  - Beat b uses `SRAM_ADDR` = (woff with its low log2(BURST_LEN) bits cleared) + b.
  - `SRAM_WE_N` = 1; `SRAM_DQ` high-Z.
  - `SRAM_DQ` is sampled into rdata slice b on the last cycle of beat b.
  - After the last beat → DONE.
- DONE: lasts one cycle, then → IDLE. If the requester still holds its request in the following IDLE cycle, a new access starts.
- `ready` (combinational):
  - IDLE: 1 when both requests are low, 0 otherwise.
  - WRITE, READ: 0.
  - DONE: 1.
- `rdata` holds its value until the next read overwrites it. Writes do not change `rdata`.
- `SRAM_DQ` is high-Z in every state except WRITE.

## Timing
- Cycle 0 is the cycle the request is first seen in IDLE; `ready` is 0 in that cycle.
- Write: `ready` = 1 in cycle WAIT_CYCLES+1 (default 6). `SRAM_WE_N` is low in cycles 1..WAIT_CYCLES.
- Read: `ready` = 1 in cycle BURST_LEN*WAIT_CYCLES+1 (default 11). `rdata` is fully valid in that cycle.
- Beat boundaries: `SRAM_ADDR` changes on the clock edge starting each beat. No dead cycle between beats.
- Reset is asynchronous and active-low and may occur mid-access. It immediately forces:
  - state IDLE;
  - `SRAM_WE_N` = 1, `SRAM_DQ` high-Z;
  - `SRAM_ADDR` = 0, `rdata` = 0;
  - counters = 0.
  - `ready` then follows the IDLE rule.
- No partial write is guaranteed after a mid-write reset.

## Structure
- Shared package `sram_ctrl_pkg`:
  - state encoding (IDLE/WRITE/READ/DONE);
  - default parameter constants;
  - the `BASE_ADDR` → word-offset helper function.
- Sub-module `sram_wait_timer`:
  - loadable down-counter of width $clog2(WAIT_CYCLES+1);
  - outputs a `last` pulse on the final cycle of each beat.
- The parent owns the FSM, the beat counter (width $clog2(BURST_LEN), absent when BURST_LEN=1) and the data latches.

## Test plan
- Write at reset defaults: addr=1024, wdata=0xDEADBEEF, wr_en held. Expect:
  - `SRAM_WE_N` low in cycles 1–5 with `SRAM_ADDR`=0 and DQ=0xDEADBEEF;
  - `ready` high in cycle 6;
  - DQ high-Z from cycle 6.
- Burst read: SRAM model preloaded with word5=0x11111111, word4=0x22222222; read addr=1044 (woff 5). Expect:
  - `SRAM_ADDR` 4 during cycles 1–5, then 5 during cycles 6–10;
  - `rdata`=0x11111111_22222222 with `ready` high in cycle 11.
- Simultaneous wr_en and rd_en at addr=1028. Expect a write to word 1 and `ready` at cycle 6; no read occurs and `rdata` is unchanged.
- Wrap-around: read addr=1020 (offset −1). Expect woff=0x1FFFF and beat addresses 0x1FFFE, 0x1FFFF.
- Reset asserted in cycle 3 of a read. Expect, immediately:
  - `SRAM_ADDR`=0, `rdata`=0, `SRAM_WE_N`=1;
  - `ready`=1 with requests low.

  After release, a new read completes normally in 11 cycles.
- Parameter sweep: WAIT_CYCLES=1 with BURST_LEN=4, and WAIT_CYCLES=3 with BURST_LEN=1. Expect read `ready` at cycle 5 and cycle 4 respectively, with correct beat ordering.
